// File: rtl/mem_pkg.sv
// Shared encodings for the data RAM path: access sizes, sequencer states, byte counts.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Request fields that are needed after acceptance to steer the response.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       sgn;
  } req_ctl_t;

  // Number of bytes touched by an access; the reserved code is treated as a word
  // so the range check stays well defined (it faults on size alone anyway).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of right-justified RAM load data to 32 bits.
// Latency: combinational.
// Backpressure: none.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] raw_i,
  output logic [31:0] data_o
);

  // Pick the fill bit from the top of the accessed field; words pass through.
  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      SZ_HALF: data_o = {{16{signed_i & raw_i[15]}}, raw_i[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: MEM-stage request -> checked, latched RAM access -> registered response.
// Latency: legal request 3 cycles accept-to-resp_valid, faulted request 1 cycle.
// Backpressure: req_ready only in IDLE; resp_ready low holds the response stable indefinitely.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned RAM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [1:0]  ram_size,
  input  logic [31:0] ram_dout,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [7:0]  fault_count
);

  state_e      state_q;
  req_ctl_t    req_q;
  logic        req_ready_q;
  logic        ram_rw_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_din_q;
  logic [1:0]  ram_size_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_fault_q;
  logic [7:0]  fault_count_q;

  logic [2:0]  req_bytes;
  logic [32:0] last_byte;
  logic        req_fault_d;
  logic [7:0]  fault_count_d;
  logic [31:0] ext_data;

  // Classify the incoming request; the last-byte sum is 33 bits wide so an
  // address near 2^32 cannot wrap back into range.
  always_comb begin
    req_bytes     = size_bytes(req_size);
    last_byte     = {1'b0, req_addr} + {30'd0, req_bytes} - 33'd1;
    req_fault_d   = (req_size == SZ_RSVD)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 || (last_byte > 33'(RAM_BYTES - 1));
    fault_count_d = (fault_count_q == 8'hFF) ? fault_count_q : fault_count_q + 8'd1;
  end

  // Extension uses the latched size/sign so the RAM output is the only live input.
  mem_load_extend u_extend (
    .size_i   (req_q.size),
    .signed_i (req_q.sgn),
    .raw_i    (ram_dout),
    .data_o   (ext_data)
  );

  // Sequencer FSM with all outputs registered; RAM pins only ever see latched values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      req_ready_q   <= 1'b1;
      ram_rw_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_size_q    <= SZ_WORD;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_fault_q  <= 1'b0;
      fault_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_q       <= '{write: req_write, size: req_size, sgn: req_signed};
            req_ready_q <= 1'b0;
            if (req_fault_d) begin
              // Faults skip the RAM entirely and answer on the next cycle.
              state_q       <= ST_RESP;
              resp_valid_q  <= 1'b1;
              resp_rdata_q  <= '0;
              resp_fault_q  <= 1'b1;
              fault_count_q <= fault_count_d;
            end else begin
              state_q    <= ST_ISSUE;
              ram_rw_q   <= req_write;
              ram_addr_q <= req_addr;
              ram_din_q  <= req_wdata;
              ram_size_q <= req_size;
            end
          end
        end
        ST_ISSUE: begin
          // The write strobe lasts exactly this one cycle.
          state_q  <= ST_CAPTURE;
          ram_rw_q <= 1'b0;
        end
        ST_CAPTURE: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= req_q.write ? 32'd0 : ext_data;
          resp_fault_q <= 1'b0;
        end
        ST_RESP: begin
          // One idle cycle always separates a response handshake from the next accept.
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign ram_rw      = ram_rw_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_size    = ram_size_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_fault  = resp_fault_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a big-endian 256-byte RAM model.
// Stimulus pushes expected responses (data, fault, first-valid cycle); a monitor pops and compares.
// Response stalls, fault sequencing and mid-access reset are covered with directed vectors.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        ram_rw;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic [1:0]  ram_size;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [7:0]  fault_count;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_BYTES(256)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .ram_rw      (ram_rw),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_size    (ram_size),
    .ram_dout    (ram_dout),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault),
    .fault_count (fault_count)
  );

  // RAM model: big-endian bytes, combinational right-justified read, write on rising edge.
  logic [7:0] mem [256];
  logic [7:0] a0;
  assign a0 = ram_addr[7:0];

  always_comb begin
    ram_dout = 32'd0;
    case (ram_size)
      SZ_BYTE: ram_dout = {24'd0, mem[a0]};
      SZ_HALF: ram_dout = {16'd0, mem[a0], mem[8'(a0 + 8'd1)]};
      default: ram_dout = {mem[a0], mem[8'(a0 + 8'd1)], mem[8'(a0 + 8'd2)], mem[8'(a0 + 8'd3)]};
    endcase
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h85; mem[1] <= 8'h12; mem[2] <= 8'h34; mem[3] <= 8'h56;
    end else if (ram_rw) begin
      case (ram_size)
        SZ_BYTE: mem[a0] <= ram_din[7:0];
        SZ_HALF: begin
          mem[a0] <= ram_din[15:8]; mem[8'(a0 + 8'd1)] <= ram_din[7:0];
        end
        default: begin
          mem[a0]              <= ram_din[31:24];
          mem[8'(a0 + 8'd1)]   <= ram_din[23:16];
          mem[8'(a0 + 8'd2)]   <= ram_din[15:8];
          mem[8'(a0 + 8'd3)]   <= ram_din[7:0];
        end
      endcase
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] exp_pc;
  } exp_t;

  exp_t exp_q[$];
  int   pc = 0;
  int   rw_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_rdata = 32'd0;
  logic        prev_fault = 1'b0;

  always @(posedge clk) pc <= pc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: latency on each new response, contents on handshake, stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (ram_rw === 1'b1) rw_cnt++;
    if (resp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: got rdata %h fault %b expected no response (t=%0t)",
                 resp_rdata, resp_fault, $time);
      end else begin
        check("resp_latency", 32'(pc), exp_q[0].exp_pc);
      end
    end
    if (resp_valid && prev_valid) begin
      check("stall_rdata_stable", resp_rdata, prev_rdata);
      check("stall_fault_stable", {31'd0, resp_fault}, {31'd0, prev_fault});
      check("stall_req_ready_low", {31'd0, req_ready}, 32'd0);
    end
    if (resp_valid && resp_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
    end
    prev_valid = resp_valid;
    prev_rdata = resp_rdata;
    prev_fault = resp_fault;
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_fault);
    int t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL req_ready_timeout: got req_ready 0 expected 1 within 100 cycles");
      return;
    end
    req_write = w; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    exp_q.push_back('{rdata: exp_rdata, fault: exp_fault, exp_pc: 32'(pc + (exp_fault ? 1 : 3))});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int rw0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_req_ready",   {31'd0, req_ready},   32'd1);
    check("rst_ram_rw",      {31'd0, ram_rw},      32'd0);
    check("rst_ram_addr",    ram_addr,             32'd0);
    check("rst_ram_din",     ram_din,              32'd0);
    check("rst_ram_size",    {30'd0, ram_size},    32'd2);
    check("rst_resp_valid",  {31'd0, resp_valid},  32'd0);
    check("rst_resp_rdata",  resp_rdata,           32'd0);
    check("rst_resp_fault",  {31'd0, resp_fault},  32'd0);
    check("rst_fault_count", {24'd0, fault_count}, 32'd0);

    reset_n = 1'b1;
    @(negedge clk);

    // Loads from the preset bytes 85 12 34 56.
    issue(1'b0, SZ_BYTE, 1'b1, 32'd0, 32'd0, 32'hFFFFFF85, 1'b0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0, 32'h00000085, 1'b0);
    issue(1'b0, SZ_HALF, 1'b1, 32'd0, 32'd0, 32'hFFFF8512, 1'b0);
    issue(1'b0, SZ_HALF, 1'b0, 32'd0, 32'd0, 32'h00008512, 1'b0);
    issue(1'b0, SZ_WORD, 1'b1, 32'd0, 32'd0, 32'h85123456, 1'b0);
    drain();

    rw0 = rw_cnt;
    issue(1'b1, SZ_WORD, 1'b0, 32'd8, 32'hE35D8AC5, 32'd0, 1'b0);
    drain();
    check("store_rw_cycles", 32'(rw_cnt - rw0), 32'd1);
    issue(1'b0, SZ_WORD, 1'b0, 32'd8, 32'd0, 32'hE35D8AC5, 1'b0);
    drain();

    rw0 = rw_cnt;
    issue(1'b0, SZ_WORD, 1'b0, 32'd2,   32'd0, 32'd0, 1'b1);
    issue(1'b0, SZ_HALF, 1'b0, 32'd5,   32'd0, 32'd0, 1'b1);
    issue(1'b1, SZ_WORD, 1'b0, 32'd254, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue(1'b0, SZ_RSVD, 1'b0, 32'd0,   32'd0, 32'd0, 1'b1);
    drain();
    check("fault_rw_cycles", 32'(rw_cnt - rw0), 32'd0);
    check("fault_count_4",   {24'd0, fault_count}, 32'd4);

    // Top-of-RAM boundary: legal byte at 255 and word at 252.
    issue(1'b1, SZ_BYTE, 1'b0, 32'd255, 32'h12345680, 32'd0, 1'b0);
    issue(1'b0, SZ_BYTE, 1'b1, 32'd255, 32'd0, 32'hFFFFFF80, 1'b0);
    issue(1'b0, SZ_WORD, 1'b0, 32'd252, 32'd0, 32'h00000080, 1'b0);
    drain();

    // Stalled response, with the next request waiting during the stall.
    resp_ready = 1'b0;
    issue(1'b0, SZ_HALF, 1'b0, 32'd2, 32'd0, 32'h00003456, 1'b0);
    for (int t = 0; t < 20 && !resp_valid; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    req_write = 1'b0; req_size = SZ_BYTE; req_signed = 1'b1; req_addr = 32'd3; req_wdata = '0;
    req_valid = 1'b1;
    exp_q.push_back('{rdata: 32'h00000056, fault: 1'b0, exp_pc: 32'(pc + 4)});
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    // Reset while a load sits in CAPTURE: no response may appear.
    req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_req_ready",   {31'd0, req_ready},   32'd1);
    check("midrst_resp_valid",  {31'd0, resp_valid},  32'd0);
    check("midrst_ram_rw",      {31'd0, ram_rw},      32'd0);
    check("midrst_fault_count", {24'd0, fault_count}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
